// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID pipeline register.
// FSM: BOOT (one idle cycle after reset), FETCH (normal), DRAIN (waits out
// an outstanding request after a redirect so its data can be dropped).
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall_cycles counter.
module fetch_stage #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pcWrite,
    input  logic         write_IFID,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] pc_IFID,
    output logic [N-1:0] instr_IFID,
    output logic         valid_IFID
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cycles
`endif
);

    localparam logic [N-1:0] NOP = N'(32'h0000_0013);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t       state, stateNext;
    logic [N-1:0] pc, pcNext;
    logic [N-1:0] redirectPc, redirectNext;
    logic [N-1:0] pcIfidNext, instrIfidNext;
    logic         validIfidNext;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= BOOT;
        else       state <= stateNext;
    end

    // Next-state, PC/redirect and IF/ID next values, memory request outputs
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        redirectNext  = redirectPc;
        pcIfidNext    = pc_IFID;
        instrIfidNext = instr_IFID;
        validIfidNext = valid_IFID;
        imem_req      = (state != BOOT);
        // pc only moves on a completed or discarded beat, so the address
        // stays stable while a request is outstanding (DRAIN shows old pc)
        imem_addr     = pc;
        case (state)
            BOOT: stateNext = FETCH;  // any late imem_ready is ignored here
            FETCH: begin
                if (branch_taken) begin
                    // redirect beats stalls: bubble regardless of write_IFID
                    instrIfidNext = NOP;
                    validIfidNext = 1'b0;
                    if (imem_ready) begin
                        pcNext = branch_target;
                    end else begin
                        redirectNext = branch_target;
                        stateNext    = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (write_IFID) begin
                        pcIfidNext    = pc;
                        instrIfidNext = imem_rdata;
                        validIfidNext = 1'b1;
                    end
                    if (pcWrite) pcNext = pc + N'(4);
                end else if (write_IFID) begin
                    instrIfidNext = NOP;
                    validIfidNext = 1'b0;
                end
            end
            DRAIN: begin
                instrIfidNext = NOP;
                validIfidNext = 1'b0;
                if (branch_taken) redirectNext = branch_target;
                if (imem_ready) begin
                    // returned data belongs to the squashed path; latest target wins
                    pcNext    = branch_taken ? branch_target : redirectPc;
                    stateNext = FETCH;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    // PC, redirect target and IF/ID pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            redirectPc <= RESET_PC;
            pc_IFID    <= '0;
            instr_IFID <= NOP;
            valid_IFID <= 1'b0;
        end else begin
            pc         <= pcNext;
            redirectPc <= redirectNext;
            pc_IFID    <= pcIfidNext;
            instr_IFID <= instrIfidNext;
            valid_IFID <= validIfidNext;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic stallEvent;
    assign stallEvent = (state == DRAIN) ||
                        ((state == FETCH) && (!pcWrite || !imem_ready));

    // Saturating count of cycles in which fetch made no forward progress
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (stallEvent && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: each stimulus cycle pushes the
// hand-computed outputs expected after the next rising edge; a monitor pops
// and compares them independently.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcWrite = 1'b0, write_IFID = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_IFID, instr_IFID;
    logic        valid_IFID;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pcI;
        logic [31:0] instr;
        logic        vld;
        int          id;
    } exp_t;

    exp_t expQ[$];

    fetch_stage #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pcWrite(pcWrite), .write_IFID(write_IFID),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc_IFID(pc_IFID), .instr_IFID(instr_IFID),
        .valid_IFID(valid_IFID)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, id, act, req);
        end
    endtask

    // Monitor: compare registered outputs just after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("imem_req",   e.id, {31'd0, imem_req},   {31'd0, e.req});
            chk("imem_addr",  e.id, imem_addr,           e.addr);
            chk("pc_IFID",    e.id, pc_IFID,             e.pcI);
            chk("instr_IFID", e.id, instr_IFID,          e.instr);
            chk("valid_IFID", e.id, {31'd0, valid_IFID}, {31'd0, e.vld});
        end
    end

    int cycId = 0;

    // One stimulus cycle: inputs applied at negedge, expected post-edge outputs queued
    task automatic cyc(input logic rst, input logic pw, input logic wi, input logic br,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rd,
                       input logic eReq, input logic [31:0] eAddr, input logic [31:0] ePc,
                       input logic [31:0] eInstr, input logic eVld);
        exp_t e;
        @(negedge clk);
        reset = rst; pcWrite = pw; write_IFID = wi; branch_taken = br;
        branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
        e.req = eReq; e.addr = eAddr; e.pcI = ePc; e.instr = eInstr; e.vld = eVld;
        e.id = cycId;
        expQ.push_back(e);
        cycId++;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        //  rst pw wi br target        rdy rdata          req addr           pc_IFID        instr          vld
        cyc(1, 0, 0, 0, 32'h0,         0, 32'h0,          0, 32'h0,         32'h0,         NOP,           0); // reset
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hDEAD_BEEF,  1, 32'h0,         32'h0,         NOP,           0); // BOOT, late ready ignored
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hA000_0000,  1, 32'h4,         32'h0,         32'hA000_0000, 1);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hA000_0004,  1, 32'h8,         32'h4,         32'hA000_0004, 1);
        cyc(0, 0, 0, 0, 32'h0,         1, 32'hA000_0008,  1, 32'h8,         32'h4,         32'hA000_0004, 1); // stall
        cyc(0, 0, 0, 0, 32'h0,         1, 32'hA000_0008,  1, 32'h8,         32'h4,         32'hA000_0004, 1);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hA000_0008,  1, 32'hC,         32'h8,         32'hA000_0008, 1); // resume
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hA000_000C,  1, 32'h10,        32'hC,         32'hA000_000C, 1);
        cyc(0, 1, 1, 0, 32'h0,         0, 32'h0,          1, 32'h10,        32'hC,         NOP,           0); // mem wait
        cyc(0, 1, 1, 0, 32'h0,         0, 32'h0,          1, 32'h10,        32'hC,         NOP,           0);
        cyc(0, 1, 1, 0, 32'h0,         0, 32'h0,          1, 32'h10,        32'hC,         NOP,           0);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hB000_0010,  1, 32'h14,        32'h10,        32'hB000_0010, 1);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hB000_0014,  1, 32'h18,        32'h14,        32'hB000_0014, 1);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hB000_0018,  1, 32'h1C,        32'h18,        32'hB000_0018, 1);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hB000_001C,  1, 32'h20,        32'h1C,        32'hB000_001C, 1);
        cyc(0, 1, 1, 1, 32'h100,       0, 32'h0,          1, 32'h20,        32'h1C,        NOP,           0); // -> DRAIN
        cyc(0, 1, 1, 0, 32'h0,         0, 32'h0,          1, 32'h20,        32'h1C,        NOP,           0);
        cyc(0, 1, 1, 1, 32'h200,       0, 32'h0,          1, 32'h20,        32'h1C,        NOP,           0); // retarget
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hDEAD_0020,  1, 32'h200,       32'h1C,        NOP,           0); // dropped
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hC000_0200,  1, 32'h204,       32'h200,       32'hC000_0200, 1);
        cyc(0, 0, 0, 1, 32'h300,       1, 32'hDEAD_0204,  1, 32'h300,       32'h200,       NOP,           0); // branch over stall
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hC000_0300,  1, 32'h304,       32'h300,       32'hC000_0300, 1);
        cyc(0, 1, 1, 1, 32'h400,       1, 32'hDEAD_0304,  1, 32'h400,       32'h300,       NOP,           0);
        cyc(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'hDEAD_0400,  1, 32'hFFFF_FFFC, 32'h300,       NOP,           0);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hC000_FFFC,  1, 32'h0,         32'hFFFF_FFFC, 32'hC000_FFFC, 1); // wrap
        cyc(0, 1, 0, 0, 32'h0,         1, 32'hC000_0000,  1, 32'h4,         32'hFFFF_FFFC, 32'hC000_FFFC, 1); // IF/ID hold
        cyc(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 32'h4,         32'hFFFF_FFFC, 32'hC000_FFFC, 1);
        cyc(0, 1, 1, 1, 32'h500,       0, 32'h0,          1, 32'h4,         32'hFFFF_FFFC, NOP,           0); // -> DRAIN
        cyc(1, 1, 1, 1, 32'h600,       1, 32'hDEAD_0004,  0, 32'h0,         32'h0,         NOP,           0); // reset mid-DRAIN
`ifdef FETCH_STALL_CNT_EN
        @(posedge clk); #2;
        chk("stall_cycles_reset", cycId, stall_cycles, 32'h0);
`endif
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hDEAD_EEEE,  1, 32'h0,         32'h0,         NOP,           0);
        cyc(0, 1, 1, 0, 32'h0,         1, 32'hD000_0000,  1, 32'h4,         32'h0,         32'hD000_0000, 1);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter N, default 32, address/data width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pcWrite, input, 1, 0 = hold PC (stall from hazard detection).
REQ-006 SHALL have port write_IFID, input, 1, 0 = hold IF/ID register contents.
REQ-007 SHALL have port branch_taken, input, 1, redirect request from ID.
REQ-008 SHALL have port branch_target, input, N, redirect address.
REQ-009 SHALL have port imem_req, output, 1, instruction memory request valid.
REQ-010 SHALL have port imem_addr, output, N, instruction memory address.
REQ-011 SHALL have port imem_ready, input, 1, memory has returned imem_rdata this cycle.
REQ-012 SHALL have port imem_rdata, input, N, fetched instruction.
REQ-013 SHALL have ports pc_IFID (output, N), instr_IFID (output, N), valid_IFID (output, 1): IF/ID pipeline register.

Function
REQ-014 SHALL implement FSM states BOOT, FETCH, DRAIN; state held in a register.
REQ-015 BOOT SHALL drive imem_req=0 for exactly one cycle after reset release, then go to FETCH.
REQ-016 FETCH SHALL drive imem_req=1, imem_addr=pc.
REQ-017 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0 (request outstanding).
REQ-018 FETCH, imem_ready=1, no branch: if write_IFID=1 load IF/ID with {pc, imem_rdata, valid=1}; if pcWrite=1 set pc<=pc+4 (mod 2^N, wraps).
REQ-019 FETCH, imem_ready=1, pcWrite=0: pc held; the same address SHALL be re-requested next cycle.
REQ-020 FETCH, imem_ready=0, no branch: pc held; if write_IFID=1 load IF/ID with bubble {pc_IFID unchanged, 32'h0000_0013, valid=0}.
REQ-021 write_IFID=0 SHALL hold all IF/ID outputs unchanged regardless of imem_ready.
REQ-022 branch_taken=1 SHALL take priority over pcWrite=0 and write_IFID=0: IF/ID loads bubble (NOP, valid=0).
REQ-023 branch_taken=1 in FETCH with imem_ready=1: discard imem_rdata, pc<=branch_target, stay FETCH.
REQ-024 branch_taken=1 in FETCH with imem_ready=0: latch branch_target into redirect_pc, go DRAIN.
REQ-025 DRAIN SHALL keep imem_req=1, imem_addr=old pc; on imem_ready=1 discard data, pc<=redirect_pc, go FETCH.
REQ-026 branch_taken=1 in DRAIN SHALL overwrite redirect_pc (latest target wins); IF/ID holds bubble throughout DRAIN.
REQ-027 Redirect-to-fetch latency SHALL be 1 cycle (new address on imem_addr the cycle after pc update).

Reset
REQ-028 reset=1 SHALL set state=BOOT, pc=RESET_PC, redirect_pc=RESET_PC, imem_req=0, pc_IFID=0, instr_IFID=32'h0000_0013, valid_IFID=0.
REQ-029 reset during DRAIN or any outstanding request SHALL abandon it; a late imem_ready in BOOT SHALL be ignored.
REQ-030 reset SHALL override branch_taken, pcWrite, write_IFID in the same cycle.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN defined: SHALL add output stall_cycles (32 bits), +1 each FETCH/DRAIN cycle with pcWrite=0 or imem_ready=0 or state=DRAIN, saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-032 Macro undefined: stall_cycles port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, imem_ready=1 always, pcWrite=write_IFID=1 -> imem_addr 0,4,8,C on consecutive cycles from cycle 2; valid_IFID=1 from cycle 3.
REQ-034 pcWrite=0, write_IFID=0 for 2 cycles at pc=0x8 -> imem_addr stays 0x8, IF/ID holds 0x4 entry; resumes 0xC after release.
REQ-035 imem_ready=0 for 3 cycles at pc=0x10 -> imem_addr stable 0x10, IF/ID bubbles (0x00000013, valid=0), then loads 0x10 entry.
REQ-036 branch_taken, target 0x100, with imem_ready=0 at pc=0x20 -> DRAIN, addr 0x20 until ready, data dropped, next addr 0x100; second branch to 0x200 during DRAIN -> 0x200.
REQ-037 branch_taken with pcWrite=0 same cycle -> pc=branch_target next cycle, valid_IFID=0.
REQ-038 reset asserted mid-DRAIN -> imem_req=0 next cycle, pc=RESET_PC; with FETCH_STALL_CNT_EN, stall_cycles=0.
